// File: rtl/obs_sprite_engine.sv
// rtl/obs_sprite_engine.sv - rectangular obstacle sprite: LFSR spawn, timed erase/step/redraw, valid/ready pixel stream (optional OBS_HBOUNCE_EN horizontal bounce)
module obs_sprite_engine #(
    parameter int         X_W             = 8,
    parameter int         Y_W             = 7,
    parameter int         SPR_W           = 2,
    parameter int         SPR_H           = 16,
    parameter int         X_MIN           = 64,
    parameter int         X_MAX           = 143,
    parameter int         Y_MAX           = 104,
    parameter int         FRAME_TICKS     = 833333,
    parameter int         FRAMES_PER_STEP = 6,
    parameter logic [2:0] COLOUR          = 3'd1
) (
    input  logic           clock,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           pix_ready,
    output logic           plot,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     colour,
    output logic           busy,
    output logic           finish,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int FW = $clog2(FRAMES_PER_STEP + 1);

    localparam logic [CW-1:0] COL_LAST   = CW'(SPR_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(SPR_H - 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(FRAME_TICKS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_DRAW,
        S_DONE,
        S_WAIT,
        S_ERASE,
        S_MOVE
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [4:0]     lfsr;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [TW-1:0]  tick;
    logic [FW-1:0]  frame;
    logic           dir_y;          // 1 = down (increasing y)
`ifdef OBS_HBOUNCE_EN
    logic           dir_x;          // 1 = right (increasing x)
`endif

    logic           pix_fire;
    logic           last_pix;
    logic           step_due;
    logic [X_W:0]   spawn_sum;

    assign pix_fire  = plot && pix_ready;
    assign last_pix  = (col == COL_LAST) && (row == ROW_LAST);
    assign step_due  = (tick == TICK_LAST) && (frame == FRAME_LAST);
    // One extra bit so the spawn sum cannot wrap before the clamp compare.
    assign spawn_sum = (X_W + 1)'(X_MIN) + (X_W + 1)'(lfsr);

    // Pixel coordinates are relative to the sprite origin; overflow truncates.
    assign x = pos_x + X_W'(col);
    assign y = pos_y + Y_W'(row);

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        next_state = state;
        plot       = 1'b0;
        colour     = 3'd0;
        busy       = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) next_state = S_SPAWN;
            end
            S_SPAWN: begin
                busy       = 1'b1;
                next_state = S_DRAW;
            end
            S_DRAW: begin
                busy   = 1'b1;
                plot   = 1'b1;
                colour = COLOUR;
                if (pix_fire && last_pix) next_state = S_DONE;
            end
            S_DONE: begin
                finish     = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                // Dropping enable erases first so nothing is left on screen.
                if (!enable || step_due) next_state = S_ERASE;
            end
            S_ERASE: begin
                busy = 1'b1;
                plot = 1'b1;
                if (pix_fire && last_pix) next_state = enable ? S_MOVE : S_IDLE;
            end
            S_MOVE: begin
                busy       = 1'b1;
                next_state = S_DRAW;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Free-running LFSR, x^5+x^3+1; the all-ones seed keeps it off zero.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 5'h1F;
        end else begin
            lfsr <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
        end
    end

    // Pixel walker: column fastest, advances only on an accepted pixel.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pix_fire) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Frame timing: ticks within a frame, frames between steps; idle outside WAIT.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tick  <= '0;
            frame <= '0;
        end else if (state == S_WAIT && enable) begin
            if (tick == TICK_LAST) begin
                tick  <= '0;
                frame <= (frame == FRAME_LAST) ? '0 : frame + FW'(1);
            end else begin
                tick <= tick + TW'(1);
            end
        end else begin
            tick  <= '0;
            frame <= '0;
        end
    end

    // Sprite position and bounce directions.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pos_x <= '0;
            pos_y <= '0;
            dir_y <= 1'b1;
`ifdef OBS_HBOUNCE_EN
            dir_x <= 1'b1;
`endif
        end else if (state == S_SPAWN) begin
            pos_x <= (spawn_sum > (X_W + 1)'(X_MAX)) ? X_W'(X_MAX) : spawn_sum[X_W-1:0];
            pos_y <= '0;
            dir_y <= 1'b1;
`ifdef OBS_HBOUNCE_EN
            dir_x <= 1'b1;
`endif
        end else if (state == S_MOVE) begin
            if (dir_y && pos_y >= Y_W'(Y_MAX)) begin
                dir_y <= 1'b0;
                pos_y <= pos_y - Y_W'(1);
            end else if (!dir_y && pos_y == '0) begin
                dir_y <= 1'b1;
                pos_y <= Y_W'(1);
            end else begin
                pos_y <= dir_y ? pos_y + Y_W'(1) : pos_y - Y_W'(1);
            end
`ifdef OBS_HBOUNCE_EN
            if (dir_x && pos_x >= X_W'(X_MAX)) begin
                dir_x <= 1'b0;
                pos_x <= pos_x - X_W'(1);
            end else if (!dir_x && pos_x <= X_W'(X_MIN)) begin
                dir_x <= 1'b1;
                pos_x <= pos_x + X_W'(1);
            end else begin
                pos_x <= dir_x ? pos_x + X_W'(1) : pos_x - X_W'(1);
            end
`endif
        end
    end

endmodule
